rf_wr_arbiter: RTL and testbench

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_wr_arbiter.sv | 111 +++++++++++
 tb/tb_rf_wr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. a small queue of
// long-latency results, with starvation bound and WAW cancellation.
module rf_wr_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic                   wb_we,
    input  logic [4:0]             wb_dest,
    input  logic [31:0]            wb_data,
    input  logic [31:0]            wb_pc,
    output logic                   wb_stall,
    input  logic                   lu_valid,
    input  logic [4:0]             lu_dest,
    input  logic [31:0]            lu_data,
    input  logic [31:0]            lu_pc,
    output logic                   lu_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic [31:0]            debug_wb_pc,
    output logic [3:0]             debug_wb_rf_we,
    output logic [4:0]             debug_wb_rf_wnum,
    output logic [31:0]            debug_wb_rf_wdata,
    output logic [$clog2(DEPTH):0] q_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

    typedef struct packed {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } q_entry_t;

    q_entry_t      q_mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [SW-1:0] starve_cnt;
    logic          q_empty, q_full, wb_req, grant_wb, grant_q, push, push_we;

    assign q_empty  = (q_count == '0);
    assign q_full   = (q_count == FULL_CNT);
    assign wb_req   = wb_valid && wb_we && (wb_dest != 5'd0);
    assign lu_ready = !reset && !q_full;
    assign push     = lu_valid && lu_ready;

    // Empty-queue escape keeps a WB request from stalling with nothing to yield to.
    assign grant_wb = !reset && wb_req && ((starve_cnt < SMAX) || q_empty);
    assign grant_q  = !reset && !grant_wb && !q_empty;
    assign wb_stall = !reset && wb_req && grant_q;

    // r0 writes and same-cycle WAW losers enter the queue already cancelled.
    assign push_we  = (lu_dest != 5'd0) && !(grant_wb && (lu_dest == wb_dest));

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (grant_wb) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (q_mem[i].dest == wb_dest) q_mem[i].we <= 1'b0;
                end
            end
            if (push) q_mem[tail] <= '{we: push_we, dest: lu_dest, data: lu_data, pc: lu_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            q_count     <= '0;
            starve_cnt  <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            debug_wb_pc <= '0;
        end else begin
            if (push)    tail <= tail + 1'b1;
            if (grant_q) head <= head + 1'b1;
            q_count <= q_count + CW'(push) - CW'(grant_q);

            if (q_empty || grant_q)  starve_cnt <= '0;
            else if (starve_cnt < SMAX) starve_cnt <= starve_cnt + 1'b1;

            rf_we <= 1'b0;
            if (grant_wb) begin
                rf_we       <= 1'b1;
                rf_waddr    <= wb_dest;
                rf_wdata    <= wb_data;
                debug_wb_pc <= wb_pc;
            end else if (grant_q) begin
                rf_we       <= q_mem[head].we;
                rf_waddr    <= q_mem[head].dest;
                rf_wdata    <= q_mem[head].data;
                debug_wb_pc <= q_mem[head].pc;
            end else if (wb_valid) begin
                debug_wb_pc <= wb_pc;
            end
        end
    end

    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized + directed bench for rf_wr_arbiter against a queue-based model.
module tb_rf_wr_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_we, lu_valid;
    logic [4:0]  wb_dest, lu_dest;
    logic [31:0] wb_data, wb_pc, lu_data, lu_pc;
    logic        wb_stall, lu_ready, rf_we;
    logic [4:0]  rf_waddr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_we;
    logic [$clog2(DEPTH):0] q_count;

    rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_pc(wb_pc), .wb_stall(wb_stall),
        .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_data(lu_data), .lu_pc(lu_pc),
        .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_pc;
    logic [31:0] m_rf [32];
    logic [31:0] d_rf [32];
    logic        m_ready;
    int          n_chk = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle: drive, check visible outputs against the model, advance the model.
    task automatic step(input logic rst, input logic wv, input logic wwe, input logic [4:0] wd,
                        input logic [31:0] wdat, input logic lv, input logic [4:0] ld,
                        input logic [31:0] ldat);
        int   n;
        logic req, gwb, gq;
        ent_t e;
        @(negedge clk);
        cyc++;
        reset = rst; wb_valid = wv; wb_we = wwe; wb_dest = wd; wb_data = wdat;
        wb_pc = 32'h1000 + 32'(cyc) * 4;
        lu_valid = lv; lu_dest = ld; lu_data = ldat; lu_pc = 32'h8000 + 32'(cyc) * 4;
        #1;
        if (rf_we === 1'b1) d_rf[rf_waddr] = rf_wdata;

        n   = mq.size();
        req = wv && wwe && (wd != 0);
        gwb = !rst && req && (m_starve < STARVE_MAX || n == 0);
        gq  = !rst && !gwb && n > 0;
        m_ready = !rst && n < DEPTH;

        chk("q_count", 32'(q_count), 32'(n));
        chk("lu_ready", 32'(lu_ready), 32'(m_ready));
        chk("wb_stall", 32'(wb_stall), 32'(!rst && req && gq));
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("dbg_we", 32'(debug_wb_rf_we), m_we ? 32'hF : 32'h0);
        chk("dbg_pc", debug_wb_pc, m_pc);
        if (m_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
            chk("rf_wdata", rf_wdata, m_data);
            chk("dbg_wnum", 32'(debug_wb_rf_wnum), 32'(m_addr));
            chk("dbg_wdata", debug_wb_rf_wdata, m_data);
        end

        if (rst) begin
            mq.delete();
            m_starve = 0; m_we = 0; m_addr = 0; m_data = 0; m_pc = 0;
        end else begin
            m_we = 0;
            if (gwb) begin
                foreach (mq[i]) if (mq[i].dest == wd) mq[i].we = 0;
                m_we = 1; m_addr = wd; m_data = wdat; m_pc = wb_pc;
                m_rf[wd] = wdat;
            end else if (gq) begin
                e = mq.pop_front();
                m_we = e.we; m_addr = e.dest; m_data = e.data; m_pc = e.pc;
                if (e.we) m_rf[e.dest] = e.data;
            end else if (wv) begin
                m_pc = wb_pc;
            end
            if (lv && n < DEPTH)
                mq.push_back('{we: (ld != 0) && !(gwb && ld == wd), dest: ld, data: ldat, pc: lu_pc});
            if (n == 0 || gq) m_starve = 0;
            else if (m_starve < STARVE_MAX) m_starve++;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int waited;
        for (int i = 0; i < 32; i++) begin m_rf[i] = 0; d_rf[i] = 0; end
        mq.delete(); m_starve = 0; m_we = 0; m_addr = 0; m_data = 0; m_pc = 0;
        reset = 1; wb_valid = 0; wb_we = 0; wb_dest = 0; wb_data = 0; wb_pc = 0;
        lu_valid = 0; lu_dest = 0; lu_data = 0; lu_pc = 0;
        repeat (2) @(posedge clk);
        // requests during reset are dropped
        step(1, 1, 1, 5'd4, 32'hDEAD, 1, 5'd6, 32'hBEEF);
        idle(1);
        chk("rst_q_count", 32'(q_count), 0);
        chk("rst_rf_we", 32'(rf_we), 0);

        // single WB write
        step(0, 1, 1, 5'd5, 32'h1234, 0, 0, 0);
        idle(1);
        chk("wb1_we", 32'(rf_we), 1);
        chk("wb1_addr", 32'(rf_waddr), 5);
        chk("wb1_data", rf_wdata, 32'h1234);
        chk("wb1_dbgwe", 32'(debug_wb_rf_we), 32'hF);

        // starvation bound: queue wins on the 5th contested cycle
        step(0, 0, 0, 0, 0, 1, 5'd3, 32'hAA);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 5'd7, 32'h700 + 32'(i), 0, 0, 0);
            chk("starve_stall", 32'(wb_stall), (i == 4) ? 1 : 0);
        end
        idle(1);
        chk("starve_addr", 32'(rf_waddr), 3);
        chk("starve_data", rf_wdata, 32'hAA);
        step(0, 1, 1, 5'd7, 32'h777, 0, 0, 0);
        chk("starve_clr", 32'(wb_stall), 0);
        idle(2);

        // full queue holds a third push until a pop
        step(0, 1, 1, 5'd7, 32'h1, 1, 5'd1, 32'h11);
        step(0, 1, 1, 5'd7, 32'h2, 1, 5'd2, 32'h22);
        step(0, 1, 1, 5'd7, 32'h3, 1, 5'd4, 32'h44);
        chk("full_ready", 32'(lu_ready), 0);
        chk("full_cnt", 32'(q_count), 2);
        waited = 0;
        while (!m_ready && waited < 12) begin
            step(0, 1, 1, 5'd7, 32'h3, 1, 5'd4, 32'h44);
            waited++;
        end
        chk("full_accept", 32'(m_ready && waited < 12), 1);
        idle(4);

        // WAW cancel: queued r9 loses to a later WB r9
        step(0, 0, 0, 0, 0, 1, 5'd9, 32'h77);
        step(0, 1, 1, 5'd9, 32'h55, 0, 0, 0);
        idle(1);
        chk("waw_we", 32'(rf_we), 1);
        chk("waw_data", rf_wdata, 32'h55);
        idle(1);
        chk("waw_drain_we", 32'(rf_we), 0);
        chk("waw_drain_cnt", 32'(q_count), 0);
        idle(1);
        chk("waw_r9", d_rf[9], 32'h55);

        // r0 filter
        step(0, 1, 1, 5'd0, 32'h99, 1, 5'd0, 32'h98);
        chk("r0_stall", 32'(wb_stall), 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("r0_we", 32'(rf_we), 0);
        end

        // reset mid-operation
        step(0, 1, 1, 5'd7, 32'h5, 1, 5'd1, 32'h61);
        step(0, 1, 1, 5'd7, 32'h6, 1, 5'd2, 32'h62);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_cnt", 32'(q_count), 2);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            chk("mid_cnt0", 32'(q_count), 0);
            chk("mid_we", 32'(rf_we), 0);
        end

        // random traffic on a small register subset to provoke WAW hits
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
        end
        idle(6);
        for (int r = 1; r < 32; r++) chk($sformatf("rf_r%0d", r), d_rf[r], m_rf[r]);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
